// File: rtl/alu_pkg.sv
// Shared ALU op codes and the multiply sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALUOP_NOP = 3'b000;
    localparam logic [2:0] ALUOP_ADD = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } mseq_state_t;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add multiply registers: running high half plus carry, multiplier/low half, multiplicand.
module mult_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             add_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] mcand
);

    logic carry;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prod_hi <= '0;
            prod_lo <= '0;
            mcand   <= '0;
            carry   <= 1'b0;
        end else if (load) begin
            prod_hi <= '0;
            prod_lo <= multiplier;
            mcand   <= multiplicand;
            carry   <= 1'b0;
        end else if (add_en) begin
            // carry holds the add overflow until the shift folds it into prod_hi's MSB
            if (prod_lo[0])
                {carry, prod_hi} <= {alu_cout, alu_result};
            else
                carry <= 1'b0;
        end else if (shift_en) begin
            {carry, prod_hi, prod_lo} <= {1'b0, carry, prod_hi, prod_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Shift-add multiply sequencer driving an external shared ALU; 2*WIDTH+1 cycle fixed latency.
module mult_sequencer #(
    parameter int         WIDTH     = 32,
    parameter logic [2:0] ALUOP_ADD = 3'b001
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         aluop,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_cout,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    import alu_pkg::mseq_state_t;
    import alu_pkg::ST_IDLE;
    import alu_pkg::ST_ADD;
    import alu_pkg::ST_SHIFT;
    import alu_pkg::ST_DONE;
    import alu_pkg::ALUOP_NOP;

    localparam int CW = $clog2(WIDTH) + 1;

    mseq_state_t    state, state_nxt;
    logic [CW-1:0]  count;
    logic           load, add_en, shift_en;
    logic [WIDTH-1:0] prod_hi, prod_lo, mcand;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (load)
                count <= '0;
            else if (shift_en)
                count <= count + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        add_en    = 1'b0;
        shift_en  = 1'b0;
        aluop     = ALUOP_NOP;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_ADD;
                end
            end
            ST_ADD: begin
                busy      = 1'b1;
                add_en    = 1'b1;
                aluop     = ALUOP_ADD;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                shift_en  = 1'b1;
                state_nxt = (count == CW'(WIDTH - 1)) ? ST_DONE : ST_ADD;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    mult_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load),
        .add_en       (add_en),
        .shift_en     (shift_en),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .prod_hi      (prod_hi),
        .prod_lo      (prod_lo),
        .mcand        (mcand)
    );

    assign alu_a   = prod_hi;
    assign alu_b   = mcand;
    assign product = {prod_hi, prod_lo};

endmodule
